// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: opcode decode, step sequencing,
// memory ready handshake with timeout, and illegal-opcode / bus-timeout fault reporting.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_zero,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [3:0] state
);
  // state   | meaning
  // FETCH   | read instruction at PC, PC+4 -> PC on mem_ready
  // DECODE  | latch opcode, compute branch target
  // MEMADR  | effective address A + sext(imm)
  // MEMRD   | load data read
  // MEMWB   | MDR -> rt
  // MEMWR   | store data write
  // EXEC    | R-type ALU op
  // ALUWB   | ALUOut -> rd
  // BRANCH  | beq compare, conditional PC load
  // ITYPEEX | immediate ALU op
  // ITYPEWB | ALUOut -> rt
  // JUMP    | jump target -> PC
  // ERR     | one-cycle fault pulse
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ITYPEEX = 4'd9,
    S_ITYPEWB = 4'd10,
    S_JUMP    = 4'd11,
    S_ERR     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t        state_q, next_state;
  logic [5:0]    op_q;
  logic [TW-1:0] tmr;
  logic [1:0]    cause_q;
  logic          mem_wait, timed_out, logic_imm;

  // PC gating with zero happens in the datapath; the flag is not needed here.
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_wait  = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                     && !mem_ready;
  assign timed_out = (TIMEOUT != 0) && mem_wait && (tmr == '0);
  assign logic_imm = (op_q == OP_ANDI) || (op_q == OP_ORI);

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:   next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             next_state = S_MEMADR;
          OP_RTYPE:                 next_state = S_EXEC;
          OP_BEQ:                   next_state = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = S_ITYPEEX;
          OP_J:                     next_state = S_JUMP;
          default:                  next_state = S_ERR;
        endcase
      end
      S_MEMADR:  next_state = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    next_state = S_ALUWB;
      S_ITYPEEX: next_state = S_ITYPEWB;
      default:   next_state = S_FETCH;
    endcase
    if (timed_out) next_state = S_ERR;
  end

  // Timer reloads on every state change, so it only measures the current wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      tmr     <= T_LOAD;
      cause_q <= '0;
    end else begin
      state_q <= next_state;
      if (state_q == S_DECODE) op_q <= opcode;
      if (next_state != state_q) tmr <= T_LOAD;
      else if (mem_wait && (tmr != '0)) tmr <= tmr - TW'(1);
      if (next_state == S_ERR) cause_q <= timed_out ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    ext_zero      = 1'b0;
    fault         = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:  alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_src        = 2'b01;
          pc_write_cond = 1'b1;
        end
        S_ITYPEEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = logic_imm ? 2'b11 : 2'b00;
          ext_zero  = logic_imm;
        end
        S_ITYPEWB: begin
          reg_write = 1'b1;
          alu_src_b = 2'b10;
          ext_zero  = logic_imm;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_ERR:   fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign fault_cause = cause_q;
  assign state       = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-opcode state paths and output tables
// from a path-level reference model, with random mem_ready stalls, timeouts and resets.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ext_zero, fault;
  logic [1:0] pc_src, alu_src_b, alu_op, fault_cause;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  logic [1:0] cause_exp = 2'b00;
  bit ready_q[$];

  typedef int iq_t[$];
  typedef struct packed {
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       ext_zero, fault;
    logic [1:0] fault_cause;
    logic [3:0] state;
  } outs_t;

  mips_multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .ext_zero(ext_zero), .fault(fault), .fault_cause(fault_cause),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic outs_t sample_dut();
    outs_t o;
    o.pc_write = pc_write;   o.pc_write_cond = pc_write_cond; o.pc_src = pc_src;
    o.iord = iord;           o.mem_read = mem_read;           o.mem_write = mem_write;
    o.ir_write = ir_write;   o.reg_write = reg_write;         o.reg_dst = reg_dst;
    o.mem_to_reg = mem_to_reg; o.alu_src_a = alu_src_a;       o.alu_src_b = alu_src_b;
    o.alu_op = alu_op;       o.ext_zero = ext_zero;           o.fault = fault;
    o.fault_cause = fault_cause; o.state = state;
    return o;
  endfunction

  // Sequence of states an instruction visits from FETCH, with no stalls.
  function automatic iq_t path_of(input logic [5:0] op);
    iq_t p;
    p.push_back(0);
    p.push_back(1);
    case (op)
      6'h23: begin p.push_back(2); p.push_back(3); p.push_back(4); end
      6'h2B: begin p.push_back(2); p.push_back(5); end
      6'h00: begin p.push_back(6); p.push_back(7); end
      6'h04: p.push_back(8);
      6'h08, 6'h0C, 6'h0D: begin p.push_back(9); p.push_back(10); end
      6'h02: p.push_back(11);
      default: p.push_back(12);
    endcase
    return p;
  endfunction

  function automatic outs_t exp_out(input int s, input logic [5:0] op, input bit mr,
                                    input logic [1:0] cause);
    outs_t o;
    bit logic_imm;
    logic_imm = (op == 6'h0C) || (op == 6'h0D);
    o = '0;
    o.state = 4'(s);
    o.fault_cause = cause;
    case (s)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      1:  o.alu_src_b = 2'b11;
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.iord = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_write = 1; o.iord = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_write = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_write_cond = 1; end
      9:  begin
            o.alu_src_a = 1; o.alu_src_b = 2'b10;
            o.alu_op = logic_imm ? 2'b11 : 2'b00; o.ext_zero = logic_imm;
          end
      10: begin o.reg_write = 1; o.alu_src_b = 2'b10; o.ext_zero = logic_imm; end
      11: begin o.pc_write = 1; o.pc_src = 2'b10; end
      12: o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Runs one instruction from FETCH back to the next FETCH entry; called at posedge+1.
  task automatic run_instr(input logic [5:0] op, input int lowpct, input int zmode,
                           input string tag, output int cycles, output int last_wait,
                           output bit faulted);
    iq_t   path;
    int    idx, waited, s;
    bit    mr;
    outs_t e, o;
    path = path_of(op);
    idx = 0; waited = 0; cycles = 0; last_wait = 0; faulted = 0;
    while (idx < path.size()) begin
      s = path[idx];
      if (ready_q.size() > 0) mr = ready_q.pop_front();
      else mr = ($urandom_range(99) >= lowpct);
      mem_ready = mr;
      opcode = (s == 1) ? op : 6'($urandom);
      zero = (zmode == 2) ? 1'($urandom) : zmode[0];
      @(negedge clk);
      e = exp_out(s, op, mr, cause_exp);
      o = sample_dut();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s op=%h cyc=%0d state: got %0d want %0d, outputs got %h want %h",
                 tag, op, cycles, o.state, e.state, o, e);
      end
      @(posedge clk); #1;
      cycles++;
      if (s == 0 || s == 3 || s == 5) begin
        if (mr) begin
          last_wait = waited + 1; waited = 0; idx++;
        end else if (waited == TIMEOUT - 1) begin
          last_wait = waited + 1; waited = 0;
          cause_exp = 2'b10; faulted = 1;
          path.delete(); path.push_back(12); idx = 0;
        end else begin
          waited++;
        end
      end else begin
        idx++;
        if (idx < path.size() && path[idx] == 12) begin
          cause_exp = 2'b01; faulted = 1;
        end
      end
      if (cycles > 4 * TIMEOUT + 40) begin
        checks++; failures++;
        $display("FAIL %s op=%h cycle budget: got %0d cycles want <= %0d", tag, op, cycles,
                 4 * TIMEOUT + 40);
        break;
      end
    end
    ready_q.delete();
  endtask

  task automatic test_reset();
    outs_t o, e;
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
    #3;
    o = sample_dut(); checks++;
    if (o !== '0) begin
      failures++; $display("FAIL reset_hold: got %h want 0", o);
    end
    @(posedge clk); #1;
    o = sample_dut(); checks++;
    if (o !== '0) begin
      failures++; $display("FAIL reset_hold_edge: got %h want 0", o);
    end
    rst = 1'b0; #1;
    e = exp_out(0, 6'h00, 1'b1, 2'b00);
    o = sample_dut(); checks++;
    if (o !== e) begin
      failures++; $display("FAIL reset_release: got %h want %h", o, e);
    end
  endtask

  task automatic test_latency();
    logic [5:0] ops[9] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h02, 6'h3F};
    int         lat[9] = '{5, 4, 4, 4, 4, 4, 3, 3, 3};
    int c, w;
    bit f;
    for (int i = 0; i < 9; i++) begin
      run_instr(ops[i], 0, 2, "latency", c, w, f);
      checks++;
      if (c != lat[i]) begin
        failures++; $display("FAIL latency op=%h: got %0d cycles want %0d", ops[i], c, lat[i]);
      end
    end
  endtask

  task automatic test_branch();
    int c, w;
    bit f;
    for (int z = 1; z >= 0; z--) begin
      run_instr(6'h04, 0, z, "beq", c, w, f);
      checks++;
      if (c != 3 || f) begin
        failures++; $display("FAIL beq zero=%0d: got %0d cycles fault=%0d want 3 cycles fault=0",
                             z, c, f);
      end
    end
  endtask

  task automatic test_illegal();
    int c, w;
    bit f;
    run_instr(6'h3F, 0, 2, "illegal", c, w, f);
    checks++;
    if (!f || fault_cause !== 2'b01 || state !== 4'd0) begin
      failures++;
      $display("FAIL illegal: got fault=%0d cause=%b state=%0d want fault=1 cause=01 state=0",
               f, fault_cause, state);
    end
  endtask

  task automatic test_timeout();
    int c, w;
    bit f;
    repeat (3) ready_q.push_back(1'b1);
    repeat (20) ready_q.push_back(1'b0);
    run_instr(6'h2B, 0, 2, "sw_timeout", c, w, f);
    checks++;
    if (!f || w != 16 || fault_cause !== 2'b10) begin
      failures++;
      $display("FAIL sw_timeout: got fault=%0d wait=%0d cause=%b want fault=1 wait=16 cause=10",
               f, w, fault_cause);
    end
    repeat (3) ready_q.push_back(1'b1);
    repeat (15) ready_q.push_back(1'b0);
    ready_q.push_back(1'b1);
    run_instr(6'h2B, 0, 2, "sw_late_ready", c, w, f);
    checks++;
    if (f || w != 16 || c != 19) begin
      failures++;
      $display("FAIL sw_late_ready: got fault=%0d wait=%0d cycles=%0d want 0 16 19", f, w, c);
    end
  endtask

  task automatic test_reset_mid();
    outs_t o, e;
    int c, w;
    bit f;
    run_instr(6'h3F, 0, 2, "prep_illegal", c, w, f);
    mem_ready = 1'b1; opcode = 6'h00;
    @(posedge clk); #1;
    opcode = 6'h2B;
    @(posedge clk); #1;
    opcode = 6'h3F;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'd5 || mem_write !== 1'b1 || fault_cause !== 2'b01) begin
      failures++;
      $display("FAIL mid_setup: got state=%0d mem_write=%b cause=%b want 5 1 01",
               state, mem_write, fault_cause);
    end
    #2 rst = 1'b1;
    #1;
    o = sample_dut(); checks++;
    if (o !== '0) begin
      failures++; $display("FAIL mid_reset_async: got %h want 0", o);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    cause_exp = 2'b00;
    e = exp_out(0, 6'h00, 1'b0, 2'b00);
    o = sample_dut(); checks++;
    if (o !== e) begin
      failures++; $display("FAIL mid_reset_release: got %h want %h", o, e);
    end
  endtask

  task automatic test_random();
    logic [5:0] legal[8] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h02};
    logic [5:0] op;
    int c, w;
    bit f;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) < 7) op = legal[$urandom_range(7)];
      else op = 6'($urandom);
      run_instr(op, $urandom_range(60), 2, "random", c, w, f);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Decodes the IR opcode and sequences fetch, decode, execute, memory and writeback.
- Drives all datapath mux selects and write enables, including ext_zero, the sign/zero-extend select for the immediate extender.
- Waits on a memory ready handshake, with timeout, and reports illegal-opcode and bus faults.

Parameters:
TIMEOUT, 16, max cycles a memory state waits for mem_ready before faulting; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
opcode  in  6  IR[31:26]; valid from the cycle after FETCH completes
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_write  out  1  register file write
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct, 11 logic-by-opcode
ext_zero  out  1  1 zero-extend imm, 0 sign-extend
fault  out  1  one-cycle fault pulse
fault_cause  out  2  01 illegal opcode, 10 memory timeout; held until next fault
state  out  4  current state encoding (debug)

Behaviour:
- Reset:
  - State forced to FETCH (0) asynchronously.
  - While rst is high, every output is 0, including fault_cause.
- Outputs are decoded from state only, except:
  - FETCH ir_write and pc_write, which equal mem_ready.
  - BRANCH pc_write_cond is a level; PC gating with zero is done in the datapath.
- Opcode latch: opcode is captured into op_q on the DECODE cycle. All later decisions and alu_op/ext_zero use op_q.
- State encodings and asserted outputs (unlisted outputs are 0):
  - 0 FETCH: mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. Goes to DECODE when mem_ready.
  - 1 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - 0x23 lw or 0x2B sw -> MEMADR
    - 0x00 R-type -> EXEC
    - 0x04 beq -> BRANCH
    - 0x08 addi, 0x0C andi, 0x0D ori -> ITYPEEX
    - 0x02 j -> JUMP
    - any other -> ERR with cause 01
  - 2 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_zero=0. Next is MEMRD for lw, MEMWR for sw.
  - 3 MEMRD: mem_read, iord=1. Goes to MEMWB when mem_ready.
  - 4 MEMWB: reg_write, reg_dst=0, mem_to_reg=1. Next is FETCH.
  - 5 MEMWR: mem_write, iord=1. Goes to FETCH when mem_ready.
  - 6 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next is ALUWB.
  - 7 ALUWB: reg_write, reg_dst=1, mem_to_reg=0. Next is FETCH.
  - 8 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond. Next is FETCH.
  - 9 ITYPEEX: alu_src_a=1, alu_src_b=10. alu_op is 00 for addi, 11 for andi/ori. ext_zero=1 for andi/ori. Next is ITYPEWB.
  - 10 ITYPEWB: reg_write, reg_dst=0, mem_to_reg=0; alu_src_b and ext_zero held from ITYPEEX. Next is FETCH.
  - 11 JUMP: pc_write, pc_src=10. Next is FETCH.
  - 12 ERR: fault=1 for one cycle; fault_cause updated on entry. Next is FETCH.
- Unused encodings 13-15 go to FETCH next cycle with all outputs 0.
- Timeout counter:
  - Counts consecutive mem_ready-low cycles in FETCH, MEMRD and MEMWR.
  - Clears on any state change.
  - When the count equals TIMEOUT-1 and mem_ready is still low, next state is ERR with cause 10. The aborted request is dropped; there is no retry.
  - mem_ready high on the timeout cycle wins: normal advance, no fault.
- Latency with mem_ready always 1, in cycles from FETCH entry to the next FETCH entry:
  - lw 5; sw 4; R-type 4; addi/andi/ori 4; beq 3; j 3; illegal 3.
- Reset mid-operation: any pending mem_read/mem_write deasserts immediately and the counter clears. fault_cause clears to 00.

Test Plan:
- lw (0x23), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
- ori (0x0D) -> state 9 shows alu_op=11, ext_zero=1, alu_src_b=10; state 10 shows reg_write=1 and ext_zero=1. addi (0x08) -> ext_zero=0, alu_op=00.
- beq with zero=1, then zero=0 -> state 8 asserts pc_write_cond=1 and pc_src=01 in both cases; pc_write=0; returns to FETCH after 3 cycles.
- Opcode 0x3F -> state 12, fault pulse for one cycle, fault_cause=01, then FETCH.
- sw with mem_ready low for 20 cycles, TIMEOUT=16 -> ERR entered after 16 cycles in MEMWR, fault_cause=10. Repeat with mem_ready rising on cycle 16 -> FETCH, no fault.
- rst asserted mid-MEMWR -> mem_write falls in the same cycle, all outputs 0. After rst falls: state=0 and mem_read=1.
